// File: rtl/axil_cfg_slave_pkg.sv
// Shared constants and types for the AXI-Lite configuration slave:
// address map, ap_ctrl bit positions, FSM encodings and tap decode helper.
package axil_cfg_slave_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h000;
  localparam int unsigned ADDR_DATA_LEN = 32'h010;
  localparam int unsigned ADDR_TAP_BASE = 32'h040;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_VALID} r_state_e;

  // Where the read data captured in R_WAIT comes from.
  typedef enum logic [1:0] {RD_SRC_REG, RD_SRC_TAP, RD_SRC_BUSY} rd_src_e;

  // Word-aligned address inside the populated part of the tap window.
  function automatic logic tap_hit(input logic [31:0] addr, input int unsigned num);
    return (addr >= ADDR_TAP_BASE) && (addr < ADDR_TAP_BASE + 4 * num) &&
           (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/axil_cfg_slave_if.sv
// AXI-Lite bus without a B channel, as used by the FIR configuration port.
interface axil_cfg_slave_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
) ();

  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   wvalid;
  logic                   wready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   arvalid;
  logic                   arready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, araddr, arvalid, rready,
    input  awready, wready, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, araddr, arvalid, rready,
    output awready, wready, arready, rdata, rvalid
  );

endinterface

// File: rtl/axil_rd_ctrl.sv
// AXI-Lite read path: address handshake, tap BRAM request, result capture
// and rvalid/rdata hold until the master accepts.
module axil_rd_ctrl
  import axil_cfg_slave_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [pADDR_WIDTH-1:0] i_araddr,
  input  logic                   i_arvalid,
  output logic                   o_arready,
  output logic [pDATA_WIDTH-1:0] o_rdata,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  input  logic                   i_idle,
  output logic                   o_tap_req,
  output logic [pADDR_WIDTH-1:0] o_tap_addr,
  input  logic                   i_tap_gnt,
  input  logic [pDATA_WIDTH-1:0] i_tap_do,
  input  logic [pDATA_WIDTH-1:0] i_reg_rdata,
  output logic [pADDR_WIDTH-1:0] o_araddr,
  output logic                   o_rd_fire
);

  r_state_e               r_state;
  rd_src_e                r_src;
  logic                   r_arready;
  logic                   r_rvalid;
  logic [pADDR_WIDTH-1:0] r_araddr;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic                   w_tap_hit;

  assign w_tap_hit  = tap_hit(32'(r_araddr), Tape_Num);
  assign o_tap_req  = (r_state == R_ADDR) && w_tap_hit && i_idle;
  assign o_tap_addr = r_araddr - pADDR_WIDTH'(ADDR_TAP_BASE);
  assign o_arready  = r_arready;
  assign o_rvalid   = r_rvalid;
  assign o_rdata    = r_rdata;
  assign o_araddr   = r_araddr;
  assign o_rd_fire  = r_rvalid && i_rready;

  // Read FSM with registered handshake and data outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= R_IDLE;
      r_src     <= RD_SRC_REG;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_araddr  <= '0;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (r_arready && i_arvalid) begin
            r_arready <= 1'b0;
            r_araddr  <= i_araddr;
            r_state   <= R_ADDR;
          end else begin
            r_arready <= i_arvalid;
          end
        end
        R_ADDR: begin
          // A tap read waits here while a config write owns the BRAM port.
          if (w_tap_hit && i_idle) begin
            if (i_tap_gnt) begin
              r_src   <= RD_SRC_TAP;
              r_state <= R_WAIT;
            end
          end else begin
            r_src   <= w_tap_hit ? RD_SRC_BUSY : RD_SRC_REG;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          unique case (r_src)
            RD_SRC_TAP:  r_rdata <= i_tap_do;
            RD_SRC_BUSY: r_rdata <= '1;
            default:     r_rdata <= i_reg_rdata;
          endcase
          r_rvalid <= 1'b1;
          r_state  <= R_VALID;
        end
        R_VALID: begin
          if (i_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_cfg_slave.sv
// AXI-Lite configuration slave for the FIR engine: ap_ctrl and data_length
// registers, tap coefficient access through the shared tap BRAM port, and
// hand-over of that port to the engine while it runs.
module axil_cfg_slave
  import axil_cfg_slave_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  axil_cfg_slave_if.slave        s_axil,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   core_tap_EN,
  input  logic [pADDR_WIDTH-1:0] core_tap_A,
  output logic                   ap_start_o,
  input  logic                   core_done,
  output logic [pDATA_WIDTH-1:0] data_length_o
);

  w_state_e               r_wstate;
  logic                   r_awready;
  logic                   r_wready;
  logic [pADDR_WIDTH-1:0] r_awaddr;

  logic                   r_ap_start;
  logic                   r_ap_done;
  logic                   r_ap_idle;
  logic                   r_ap_start_o;
  logic [pDATA_WIDTH-1:0] r_data_length;

  logic                   w_wr_fire;
  logic                   w_tap_wr;
  logic                   w_wr_ctrl;
  logic                   w_wr_len;
  logic                   w_rd_tap_req;
  logic                   w_rd_tap_gnt;
  logic [pADDR_WIDTH-1:0] w_rd_tap_addr;
  logic [pADDR_WIDTH-1:0] w_rd_addr;
  logic                   w_rd_fire;
  logic                   w_rd_ctrl_fire;
  logic [pDATA_WIDTH-1:0] w_reg_rdata;

  assign s_axil.awready = r_awready;
  assign s_axil.wready  = r_wready;
  assign ap_start_o     = r_ap_start_o;
  assign data_length_o  = r_data_length;

  assign w_wr_fire = (r_wstate == W_DATA) && r_wready && s_axil.wvalid;
  // Reset gating keeps a write caught mid-reset from reaching the BRAM.
  assign w_tap_wr  = axis_rst_n && w_wr_fire && r_ap_idle &&
                     tap_hit(32'(r_awaddr), Tape_Num);
  assign w_wr_ctrl = w_wr_fire && (r_awaddr == pADDR_WIDTH'(ADDR_AP_CTRL));
  assign w_wr_len  = w_wr_fire && r_ap_idle && (r_awaddr == pADDR_WIDTH'(ADDR_DATA_LEN));

  assign w_rd_tap_gnt   = !w_tap_wr;
  assign w_rd_ctrl_fire = w_rd_fire && (w_rd_addr == pADDR_WIDTH'(ADDR_AP_CTRL));

  // Write FSM: one-cycle awready, then wready held until the data beat.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_awaddr  <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (r_awready && s_axil.awvalid) begin
            r_awready <= 1'b0;
            r_awaddr  <= s_axil.awaddr;
            r_wstate  <= W_ADDR;
          end else begin
            r_awready <= s_axil.awvalid;
          end
        end
        W_ADDR: begin
          r_wready <= 1'b1;
          r_wstate <= W_DATA;
        end
        W_DATA: begin
          if (w_wr_fire) begin
            r_wready <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ap_ctrl / data_length state; core_done outranks the read-to-clear of ap_done.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_ap_start    <= 1'b0;
      r_ap_done     <= 1'b0;
      r_ap_idle     <= 1'b1;
      r_ap_start_o  <= 1'b0;
      r_data_length <= '0;
    end else begin
      r_ap_start_o <= r_ap_start;
      if (r_ap_start) begin
        r_ap_start <= 1'b0;
        r_ap_idle  <= 1'b0;
      end else if (w_wr_ctrl && s_axil.wdata[AP_START_BIT] && r_ap_idle) begin
        r_ap_start <= 1'b1;
      end
      if (w_rd_ctrl_fire) begin
        r_ap_done <= 1'b0;
      end
      if (core_done) begin
        r_ap_done <= 1'b1;
        r_ap_idle <= 1'b1;
      end
      if (w_wr_len) begin
        r_data_length <= s_axil.wdata;
      end
    end
  end

  // Register read data for the address latched by the read path.
  always_comb begin
    w_reg_rdata = '0;
    if (w_rd_addr == pADDR_WIDTH'(ADDR_AP_CTRL)) begin
      w_reg_rdata[AP_START_BIT] = r_ap_start;
      w_reg_rdata[AP_DONE_BIT]  = r_ap_done;
      w_reg_rdata[AP_IDLE_BIT]  = r_ap_idle;
    end else if (w_rd_addr == pADDR_WIDTH'(ADDR_DATA_LEN)) begin
      w_reg_rdata = r_data_length;
    end
  end

  // Tap BRAM arbiter: engine while busy, else config write before config read.
  always_comb begin
    tap_WE = 4'b0000;
    tap_EN = 1'b0;
    tap_Di = s_axil.wdata;
    tap_A  = '0;
    if (axis_rst_n) begin
      if (!r_ap_idle) begin
        tap_EN = core_tap_EN;
        tap_A  = core_tap_A;
      end else if (w_tap_wr) begin
        tap_WE = 4'b1111;
        tap_EN = 1'b1;
        tap_A  = r_awaddr - pADDR_WIDTH'(ADDR_TAP_BASE);
      end else if (w_rd_tap_req) begin
        tap_EN = 1'b1;
        tap_A  = w_rd_tap_addr;
      end
    end
  end

  axil_rd_ctrl #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .Tape_Num    (Tape_Num)
  ) u_rd_ctrl (
    .i_clk       (axis_clk),
    .i_rst_n     (axis_rst_n),
    .i_araddr    (s_axil.araddr),
    .i_arvalid   (s_axil.arvalid),
    .o_arready   (s_axil.arready),
    .o_rdata     (s_axil.rdata),
    .o_rvalid    (s_axil.rvalid),
    .i_rready    (s_axil.rready),
    .i_idle      (r_ap_idle),
    .o_tap_req   (w_rd_tap_req),
    .o_tap_addr  (w_rd_tap_addr),
    .i_tap_gnt   (w_rd_tap_gnt),
    .i_tap_do    (tap_Do),
    .i_reg_rdata (w_reg_rdata),
    .o_araddr    (w_rd_addr),
    .o_rd_fire   (w_rd_fire)
  );

endmodule

// File: tb/tb_axil_cfg_slave.sv
// Scoreboard bench for axil_cfg_slave: read tasks push expected rdata,
// a monitor pops and compares on every rvalid&rready beat.
module tb_axil_cfg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;
  logic        core_tap_EN = 1'b0;
  logic [11:0] core_tap_A = '0;
  logic        ap_start_o;
  logic        core_done = 1'b0;
  logic [31:0] data_length_o;

  always #5 clk = ~clk;

  axil_cfg_slave_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  axil_cfg_slave #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk      (clk),
    .axis_rst_n    (rst_n),
    .s_axil        (bus),
    .tap_WE        (tap_WE),
    .tap_EN        (tap_EN),
    .tap_Di        (tap_Di),
    .tap_A         (tap_A),
    .tap_Do        (tap_Do),
    .core_tap_EN   (core_tap_EN),
    .core_tap_A    (core_tap_A),
    .ap_start_o    (ap_start_o),
    .core_done     (core_done),
    .data_length_o (data_length_o)
  );

  // Tap BRAM model, one-cycle read latency, byte write enables.
  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) mem[tap_A[7:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= mem[tap_A[7:2]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int start_cnt = 0;
  int we_base;
  int start_base;
  logic [31:0] exp_q  [$];
  logic [11:0] addr_q [$];
  logic [31:0] mon_e;
  logic [11:0] mon_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake did not occur within cycle budget", name);
  endtask

  always @(negedge clk) begin
    if (tap_WE != 4'b0000) we_cnt++;
    if (ap_start_o) start_cnt++;
  end

  // Monitor: compare each accepted read beat with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rvalid && bus.rready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected read beat: got 0x%08h, expected none", bus.rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = addr_q.pop_front();
        check($sformatf("rdata[0x%03h]", mon_a), bus.rdata, mon_e);
      end
    end
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    bit ok;
    bus.awaddr = a; bus.awvalid = 1'b1; bus.wdata = d; bus.wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1; bus.awvalid = 1'b0;
    if (!ok) timeout($sformatf("awready[0x%03h]", a));
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1; bus.wvalid = 1'b0;
    if (!ok) timeout($sformatf("wready[0x%03h]", a));
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] e, input int exp_lat,
                          input int hold, input bit done_at_hs);
    bit ok;
    int lat;
    logic [31:0] first;
    exp_q.push_back(e);
    addr_q.push_back(a);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1; bus.arvalid = 1'b0;
    if (!ok) timeout($sformatf("arready[0x%03h]", a));
    ok = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rvalid) begin ok = 1'b1; lat = i; break; end
    end
    if (!ok) timeout($sformatf("rvalid[0x%03h]", a));
    else if (exp_lat != 0) check($sformatf("rvalid latency[0x%03h]", a), 32'(lat), 32'(exp_lat));
    first = bus.rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid held", {31'b0, bus.rvalid}, 32'd1);
      check("rdata held", bus.rdata, first);
    end
    @(posedge clk); #1;
    bus.rready = 1'b1;
    if (done_at_hs) core_done = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    core_done = 1'b0;
  endtask

  logic [31:0] taps [11];

  initial begin
    taps = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63, 32'd56, 32'd23,
             -32'sd9, -32'sd10, 32'd0};
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst awready", {31'b0, bus.awready}, 32'd0);
    check("rst wready", {31'b0, bus.wready}, 32'd0);
    check("rst arready", {31'b0, bus.arready}, 32'd0);
    check("rst rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("rst rdata", bus.rdata, 32'd0);
    check("rst tap_WE", {28'b0, tap_WE}, 32'd0);
    check("rst tap_EN", {31'b0, tap_EN}, 32'd0);
    check("rst ap_start_o", {31'b0, ap_start_o}, 32'd0);
    check("rst data_length_o", data_length_o, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    axi_read(12'h000, 32'h4, 3, 0, 1'b0);

    // Programming data_length and taps, then read back.
    axi_write(12'h010, 32'd600);
    @(negedge clk);
    check("data_length_o", data_length_o, 32'd600);
    @(posedge clk); #1;
    we_base = we_cnt;
    for (int k = 0; k < 11; k++) axi_write(12'h040 + 12'(4 * k), taps[k]);
    @(negedge clk);
    check("tap_WE pulses", 32'(we_cnt - we_base), 32'd11);
    @(posedge clk); #1;
    for (int k = 0; k < 11; k++) axi_read(12'h040 + 12'(4 * k), taps[k], 3, 0, 1'b0);

    // rready stall, unmapped and out-of-range tap addresses.
    axi_read(12'h010, 32'd600, 3, 5, 1'b0);
    axi_read(12'h020, 32'd0, 3, 0, 1'b0);
    axi_write(12'h06C, 32'd5);
    axi_read(12'h06C, 32'd0, 3, 0, 1'b0);
    check("tap_WE on unmapped", 32'(we_cnt - we_base), 32'd11);

    // Write and read hit the tap port in the same cycle: read stalls once.
    fork
      axi_write(12'h048, 32'd77);
      begin
        @(posedge clk); #1;
        axi_read(12'h04C, 32'd23, 4, 0, 1'b0);
      end
    join
    axi_read(12'h048, 32'd77, 3, 0, 1'b0);

    // Start the engine.
    start_base = start_cnt;
    axi_write(12'h000, 32'h1);
    repeat (4) @(negedge clk);
    check("ap_start_o pulse cycles", 32'(start_cnt - start_base), 32'd1);
    @(posedge clk); #1;
    axi_read(12'h000, 32'h0, 3, 0, 1'b0);

    // Busy: engine owns the BRAM, config accesses are blocked.
    core_tap_EN = 1'b1;
    core_tap_A  = 12'h008;
    @(negedge clk);
    check("busy tap_A", {20'b0, tap_A}, 32'h8);
    check("busy tap_EN", {31'b0, tap_EN}, 32'd1);
    check("busy tap_WE", {28'b0, tap_WE}, 32'd0);
    @(posedge clk); #1;
    we_base = we_cnt;
    axi_write(12'h044, 32'd99);
    axi_write(12'h010, 32'd1234);
    axi_write(12'h000, 32'h1);
    axi_read(12'h044, 32'hFFFF_FFFF, 3, 0, 1'b0);
    check("tap_WE while busy", 32'(we_cnt - we_base), 32'd0);
    check("data_length while busy", data_length_o, 32'd600);
    check("start ignored while busy", 32'(start_cnt - start_base), 32'd1);
    core_tap_EN = 1'b0;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    axi_read(12'h044, 32'hFFFF_FFF6, 3, 0, 1'b0);
    check("data_length after done", data_length_o, 32'd600);
    axi_read(12'h000, 32'h6, 3, 0, 1'b0);
    axi_read(12'h000, 32'h4, 3, 0, 1'b0);

    // core_done coincident with the read-to-clear handshake keeps ap_done.
    axi_write(12'h000, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    axi_read(12'h000, 32'h6, 3, 0, 1'b1);
    axi_read(12'h000, 32'h6, 3, 0, 1'b0);
    axi_read(12'h000, 32'h4, 3, 0, 1'b0);
    check("total ap_start_o pulses", 32'(start_cnt - start_base), 32'd2);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/axil_cfg_slave.md
AXIL_CFG_SLAVE -- requirements
Module: axil_cfg_slave

Interface
REQ-001 Parameters SHALL be:
  - pADDR_WIDTH, 12, address width
  - pDATA_WIDTH, 32, data width
  - Tape_Num, 11, number of tap coefficients
REQ-002 axis_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 axis_rst_n  in  1  reset; synchronous, active-low.
REQ-004 awaddr/awvalid/awready  in/in/out  12/1/1  AXI-Lite write address channel.
REQ-005 wdata/wvalid/wready  in/in/out  32/1/1  AXI-Lite write data channel; there is no B channel.
REQ-006 araddr/arvalid/arready  in/in/out  12/1/1  AXI-Lite read address channel.
REQ-007 rdata/rvalid/rready  out/out/in  32/1/1  AXI-Lite read data channel.
REQ-008 tap_WE/tap_EN/tap_Di/tap_A/tap_Do  out/out/out/out/in  4/1/32/12/32  tap BRAM port; read latency is 1 cycle.
REQ-009 core_tap_EN/core_tap_A  in/in  1/12  tap BRAM request from the FIR engine.
REQ-010 ap_start_o  out  1  one-cycle start pulse to the engine.
REQ-011 core_done  in  1  one-cycle completion pulse from the engine.
REQ-012 data_length_o  out  32  programmed sample count.

Function
REQ-013 The address map SHALL be:
  - 0x00 ap_ctrl: bit0 ap_start, bit1 ap_done, bit2 ap_idle
  - 0x10 data_length
  - 0x40+4k, k=0..Tape_Num-1: tap k, stored in tap BRAM at address 4k
REQ-014 Write FSM SHALL follow W_IDLE -> W_ADDR -> W_DATA -> W_IDLE:
  - awready high one cycle in W_IDLE when awvalid; latch awaddr.
  - wready high continuously in W_DATA; write occurs on wvalid&wready, then return to W_IDLE.
REQ-015 Read FSM SHALL follow R_IDLE -> R_ADDR -> R_WAIT -> R_VALID -> R_IDLE:
  - arready high one cycle on arvalid; latch araddr.
  - R_ADDR drives the BRAM read when the address is in the tap region.
  - R_WAIT captures the result.
  - R_VALID holds rvalid and stable rdata until rready.
REQ-016 The write and read FSMs SHALL be independent; simultaneous write and read to tap space SHALL give the write priority on tap_A, with the read stalled one cycle in R_ADDR.
REQ-017 A write of 0x00 with bit0=1 SHALL set ap_start only when ap_idle=1; it is ignored otherwise.
REQ-018 When ap_start=1, the next cycle SHALL pulse ap_start_o, clear ap_start, and clear ap_idle.
REQ-019 core_done SHALL set ap_done and ap_idle.
REQ-020 A completed read of 0x00 (rvalid&rready) SHALL clear ap_done, unless core_done is asserted in the same cycle, in which case ap_done stays set.
REQ-021 While ap_idle=0, the engine SHALL own the tap BRAM (tap_A=core_tap_A, tap_EN=core_tap_EN, tap_WE=0):
  - config tap writes are dropped;
  - config tap reads return 0xFFFFFFFF;
  - data_length writes are dropped.
REQ-022 Unmapped addresses SHALL read 0 and ignore writes; tap offsets at or beyond Tape_Num SHALL be treated as unmapped.
REQ-023 A tap write SHALL drive tap_WE=4'b1111, tap_EN=1, and tap_Di=wdata for exactly one cycle.

Reset
REQ-024 During reset the outputs SHALL be:
  - awready, wready, arready, rvalid: 0
  - rdata: 0
  - tap_WE: 0, tap_EN: 0
  - ap_start_o: 0
  - data_length_o: 0
  - ap_ctrl: 0x4 (idle)
  - both FSMs in IDLE
REQ-025 Reset mid-transaction SHALL abandon that transaction without a BRAM write; tap BRAM contents are not cleared.

Structure
REQ-026 A shared package SHALL hold the address constants (ADDR_AP_CTRL, ADDR_DATA_LEN, ADDR_TAP_BASE), the ap_ctrl bit indices, and the FSM state encodings.
REQ-027 The read path SHALL be one sub-module, axil_rd_ctrl; the write path and the arbiter stay inline.

Verification
REQ-028 Reset, then read 0x00 -> rdata=0x4 and rvalid high 3 cycles after the arready handshake.
REQ-029 Write 0x10=600, write taps 0x40..0x68 = {0,-10,-9,23,56,63,56,23,-9,-10,0}, read all back -> exact match; tap_WE pulses exactly 11 times.
REQ-030 Write 0x00=1 -> ap_start_o pulses exactly one cycle; the next read of 0x00 returns 0x0.
REQ-031 While busy, write 0x44=99, then read 0x44 -> rdata=0xFFFFFFFF; after core_done, read 0x44 -> -10 and data_length unchanged.
REQ-032 After core_done, read 0x00 twice -> 0x6, then 0x4; core_done coincident with the rready handshake -> ap_done stays 1.
REQ-033 Hold rready=0 for 5 cycles -> rvalid and rdata held stable; reading 0x20 -> 0.
